// File: rtl/radiant_readout_pkg.sv
// Shared types and defaults for the RADIANT event readout block.
package radiant_readout_pkg;

  localparam int unsigned LEN_WIDTH_DEF = 12;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam logic [DATA_WIDTH-1:0] PAD_WORD_DEF = 32'hDEADDEAD;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4,
    WAITLOW = 3'd5
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/radiant_readout_skid.sv
// Two-entry skid buffer between the FIFO read port and the AXI4-Stream master.
module radiant_readout_skid
  import radiant_readout_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic [1:0]            count_o
);

  beat_t      head_q, head_d, tail_q, tail_d;
  logic       head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic [1:0] count_q, count_d;
  logic       pop_c;
  beat_t      in_beat_c;

  assign pop_c     = head_vld_q && out_ready_i;
  assign in_beat_c = '{last: in_last_i, data: in_data_i};

  // Head is the presented beat; tail only fills while the head is stalled.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop_c) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = in_valid_i;
        if (in_valid_i) tail_d = in_beat_c;
      end else begin
        head_vld_d = in_valid_i;
        if (in_valid_i) head_d = in_beat_c;
      end
    end else if (in_valid_i) begin
      if (!head_vld_q) begin
        head_vld_d = 1'b1;
        head_d     = in_beat_c;
      end else begin
        tail_vld_d = 1'b1;
        tail_d     = in_beat_c;
      end
    end
    count_d = 2'(head_vld_d) + 2'(tail_vld_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      count_q    <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
      count_q    <= count_d;
    end
  end

  assign out_valid_o = head_vld_q;
  assign out_data_o  = head_q.data;
  assign out_last_o  = head_q.last;
  assign count_o     = count_q;

endmodule

// File: rtl/radiant_event_readout.sv
// Event readout: acks the event core, streams a fixed-length FIFO record as AXI4-Stream.
// Optional starvation abort with pad fill is enabled by RADIANT_READOUT_TIMEOUT_EN.
module radiant_event_readout
  import radiant_readout_pkg::*;
#(
  parameter int unsigned           LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] PAD_WORD       = PAD_WORD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [LEN_WIDTH-1:0]  event_len_i,
  input  logic                  event_ready_i,
  output logic                  event_readout_ready_o,
  output logic                  event_done_o,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_dat_i,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [15:0]           event_count_o
);

  // One extra bit so a zero length field represents 2^LEN_WIDTH words.
  localparam int unsigned CNT_W = LEN_WIDTH + 1;

  state_e                 state_q;
  logic [CNT_W-1:0]       rem_q, beats_q;
  logic                   inflight_q, inflight_last_q, inflight_pad_q;
  logic                   ack_q, done_q, busy_q, err_q;
  logic [15:0]            count_q;

  logic                   sk_valid, sk_last;
  logic [DATA_WIDTH-1:0]  sk_data;
  logic [1:0]             sk_count;
  logic                   hs_c, credit_ok_c, issue_c, rem_one_c, abort_c;
  logic [2:0]             occ_c;
  logic [CNT_W-1:0]       len_ext_c;
  logic [DATA_WIDTH-1:0]  push_data_c;

  assign hs_c      = sk_valid && m_tready;
  assign rem_one_c = (rem_q == CNT_W'(1));
  assign len_ext_c = {event_len_i == '0, event_len_i};

  // Occupancy after this cycle's pop: a read issued now lands one cycle later.
  assign occ_c       = 3'(inflight_q) + 3'(sk_count) - 3'(hs_c);
  assign credit_ok_c = (occ_c < 3'd2);
  assign issue_c     = (state_q == STREAM) && (rem_q != '0) && credit_ok_c &&
                       (abort_c || !fifo_empty_i);
  assign fifo_rd_o   = issue_c && !abort_c;
  assign push_data_c = inflight_pad_q ? PAD_WORD : fifo_dat_i;

`ifdef RADIANT_READOUT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          abort_q;
  logic [TW-1:0] starve_q;
  assign abort_c = abort_q;
`else
  logic unused_timeout;
  assign abort_c        = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      rem_q           <= '0;
      beats_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_pad_q  <= 1'b0;
      ack_q           <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      count_q         <= '0;
`ifdef RADIANT_READOUT_TIMEOUT_EN
      abort_q         <= 1'b0;
      starve_q        <= '0;
`endif
    end else begin
      ack_q           <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= issue_c;
      inflight_last_q <= issue_c && rem_one_c;
      inflight_pad_q  <= issue_c && abort_c;
      if (issue_c) rem_q <= rem_q - CNT_W'(1);
      if (hs_c)    beats_q <= beats_q - CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (event_ready_i && enable_i) begin
            rem_q   <= len_ext_c;
            beats_q <= len_ext_c;
            err_q   <= 1'b0;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ACK;
`ifdef RADIANT_READOUT_TIMEOUT_EN
            abort_q  <= 1'b0;
            starve_q <= '0;
`endif
          end
        end
        ACK:    state_q <= STREAM;
        STREAM: if (issue_c && rem_one_c) state_q <= DRAIN;
        DRAIN: begin
          if (hs_c && beats_q == CNT_W'(1)) begin
            done_q  <= 1'b1;
            count_q <= count_q + 16'd1;
            state_q <= DONE;
          end
        end
        DONE:   state_q <= WAITLOW;
        // A level still high from the finished event must not retrigger.
        WAITLOW: begin
          if (!event_ready_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase

`ifdef RADIANT_READOUT_TIMEOUT_EN
      if (state_q == STREAM && !abort_q) begin
        if (issue_c) begin
          starve_q <= '0;
        end else if (rem_q != '0) begin
          if (starve_q == TW'(TIMEOUT_CYCLES - 1)) begin
            abort_q <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            starve_q <= starve_q + TW'(1);
          end
        end
      end
`endif
    end
  end

  radiant_readout_skid u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (inflight_q),
    .in_data_i   (push_data_c),
    .in_last_i   (inflight_last_q),
    .out_valid_o (sk_valid),
    .out_ready_i (m_tready),
    .out_data_o  (sk_data),
    .out_last_o  (sk_last),
    .count_o     (sk_count)
  );

  assign m_tvalid              = sk_valid;
  assign m_tdata               = sk_data;
  assign m_tlast               = sk_last;
  assign event_readout_ready_o = ack_q;
  assign event_done_o          = done_q;
  assign busy_o                = busy_q;
  assign err_o                 = err_q;
  assign event_count_o         = count_q;

endmodule
